mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 9, word address width of the shared RAM (512 words).
REQ-002 Parameter DATA_W, 32, data word width.
REQ-003 Port Clock  input  1  single clock; all state changes on rising edge.
REQ-004 Port Resetn  input  1  asynchronous, active-low reset.
REQ-005 Ports req_a / req_b  input  1  request from port A (instruction fetch) / port B (data).
REQ-006 Ports we_a / we_b  input  1  1 = write, 0 = read.
REQ-007 Ports addr_a / addr_b  input  ADDR_W  word address.
REQ-008 Ports wdata_a / wdata_b  input  DATA_W  write data.
REQ-009 Ports gnt_a / gnt_b  output  1  one-cycle accept pulse.
REQ-010 Ports done_a / done_b  output  1  one-cycle completion pulse.
REQ-011 Ports rdata_a / rdata_b  output  DATA_W  read result, valid when done_x=1 for a read.
REQ-012 Port mem_read  output  1  drives RAM Read.
REQ-013 Port mem_write  output  1  drives RAM Write.
REQ-014 Port mem_addr  output  ADDR_W  drives RAM Address.
REQ-015 Port mem_wdata  output  DATA_W  drives RAM Mdatain.
REQ-016 Port mem_rdata  input  DATA_W  from RAM data_output; RAM registers it on the rising edge where mem_read=1.

Function
REQ-017 FSM states: IDLE, ACCESS, CAPTURE; the block serves one transaction at a time.
REQ-018 gnt_x is combinational and is asserted only in IDLE, to at most one port per cycle.
REQ-019 Arbitration: one requester -> grant it; both -> grant the port not granted last (round-robin); last_grant resets to B, so A wins the first tie.
REQ-020 On a grant edge: latch we, addr, wdata and port id; update last_grant; state -> ACCESS; set mem_addr/mem_wdata; set mem_read=!we or mem_write=we.
REQ-021 mem_read and mem_write are registered, high only during the ACCESS cycle, and never both 1.
REQ-022 ACCESS, write: state -> IDLE; done_x=1 the next cycle; grant-to-done latency 2 cycles.
REQ-023 ACCESS, read: state -> CAPTURE; mem_read=0 in CAPTURE.
REQ-024 CAPTURE: at the edge, rdata_x <= mem_rdata and done_x <= 1; state -> IDLE; grant-to-done latency 3 cycles.
REQ-025 rdata_x holds its value until the next read completion on the same port; rdata of the other port is unaffected.
REQ-026 A requester holds req/we/addr/wdata stable until gnt; after gnt it may change them freely without affecting the transaction in flight.
REQ-027 Deasserting req before gnt withdraws the request with no side effect.
REQ-028 Requests seen in ACCESS or CAPTURE are not granted; they are arbitrated on return to IDLE. The IDLE cycle in which done_x is high may grant a new transaction.
REQ-029 mem_addr and mem_wdata hold their last values outside ACCESS.

Reset
REQ-030 Resetn=0 forces immediately, without a clock edge: state=IDLE, last_grant=B, and all outputs zero (gnt, done, rdata, mem_read, mem_write, mem_addr, mem_wdata).
REQ-031 Reset during ACCESS or CAPTURE abandons the transaction: no done pulse, and no RAM write occurs at an edge where Resetn=0.
REQ-032 The first grant is possible in the first cycle after Resetn rises.

Verification
REQ-033 Reset, then A writes 0xDEADBEEF to addr 5 -> gnt_a at cycle 0, mem_write=1 with mem_addr=5 at cycle 1, done_a at cycle 2.
REQ-034 Then B reads addr 5 -> mem_read=1 at cycle 1, done_b at cycle 3 with rdata_b=0xDEADBEEF; rdata_a is unchanged.
REQ-035 req_a and req_b both held continuously -> grants alternate A,B,A,B; exactly one gnt per transaction; mem_read and mem_write are never both high.
REQ-036 req_b raised while A's read is in CAPTURE -> gnt_b only in the next IDLE cycle, coincident with done_a.
REQ-037 Resetn pulsed low during A's write ACCESS cycle -> mem_write drops at once, RAM addr unchanged on readback, no done_a; after release, a tie grants A first.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/grant/completion bundle for two requesters plus the shared RAM port
interface mem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req_a, req_b;
  logic              we_a, we_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] wdata_a, wdata_b;
  logic              gnt_a, gnt_b;
  logic              done_a, done_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // arbiter side: takes requests and RAM read data, drives grants, completions and the RAM controls
  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_rdata,
    output gnt_a, gnt_b, done_a, done_b, rdata_a, rdata_b,
           mem_read, mem_write, mem_addr, mem_wdata
  );
  // requester/RAM side: the mirror image of the arbiter
  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_rdata,
    input  gnt_a, gnt_b, done_a, done_b, rdata_a, rdata_b,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter serving one RAM transaction at a time for ports A and B
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic         Clock,
  input  logic         Resetn,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;
  state_t            state;
  logic              last_b;
  logic              pick_a;
  logic              we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  // grant only in IDLE; on a tie the port not served last wins; last_b also names the port in flight
  always_comb begin
    pick_a    = bus.req_a & (~bus.req_b | last_b);
    bus.gnt_a = Resetn & (state == IDLE) & pick_a;
    bus.gnt_b = Resetn & (state == IDLE) & bus.req_b & ~pick_a;
    we_sel    = bus.gnt_b ? bus.we_b    : bus.we_a;
    addr_sel  = bus.gnt_b ? bus.addr_b  : bus.addr_a;
    wdata_sel = bus.gnt_b ? bus.wdata_b : bus.wdata_a;
  end
  // IDLE -> ACCESS on grant; ACCESS completes writes or moves reads to CAPTURE; CAPTURE latches RAM data
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state         <= IDLE;
      last_b        <= 1'b1;
      bus.done_a    <= 1'b0;
      bus.done_b    <= 1'b0;
      bus.rdata_a   <= '0;
      bus.rdata_b   <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.done_a    <= 1'b0;
      bus.done_b    <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      case (state)
        IDLE: if (bus.gnt_a | bus.gnt_b) begin
          state         <= ACCESS;
          last_b        <= bus.gnt_b;
          bus.mem_addr  <= addr_sel;
          bus.mem_wdata <= wdata_sel;
          bus.mem_read  <= ~we_sel;
          bus.mem_write <= we_sel;
        end
        ACCESS: begin
          state      <= bus.mem_write ? IDLE : CAPTURE;
          bus.done_a <= bus.mem_write & ~last_b;
          bus.done_b <= bus.mem_write & last_b;
        end
        CAPTURE: begin
          state      <= IDLE;
          bus.done_a <= ~last_b;
          bus.done_b <= last_b;
          if (last_b) bus.rdata_b <= bus.mem_rdata;
          else bus.rdata_a <= bus.mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
